alt_vipcts131_common_control_packet_decoder: RTL and testbench
==============================================================

// Module: alt_vipcts131_common_control_packet_decoder
// PURPOSE
//  Input-side parser for VIP Avalon-ST streams; sits in front of the user algorithm, mirroring the output-side encoder.
//  Classifies each packet by the type nibble in its sop beat. Decodes control packets (type 0xF) into width/height/interlaced.
//  Forwards video payload (type 0) with the header beat stripped and flags the last beat with end_of_video.
//  Consumes and drops all other packet types.
// PARAMETERS
//  BITS_PER_SYMBOL   8  bits per symbol; only the low 4 bits of each symbol carry control nibbles
//  SYMBOLS_PER_BEAT  3  symbols per beat; symbol 0 occupies data[BITS_PER_SYMBOL-1:0]
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  din_ready        out  1      Avalon-ST sink (external stream)
//  din_valid        in   1
//  din_sop          in   1
//  din_eop          in   1
//  din_data         in   BPS*SPB
//  dout_ready       in   1      Avalon-ST source (to user algorithm), video payload only
//  dout_valid       out  1
//  dout_data        out  BPS*SPB
//  end_of_video     out  1      qualifies the last video beat (valid only with dout_valid)
//  width            out  16     last complete control packet, registered
//  height           out  16
//  interlaced       out  4
//  vip_ctrl_valid   out  1      1-cycle pulse: width/height/interlaced just updated
//  protocol_error   out  1      1-cycle pulse: truncated control packet or sop inside an open packet
// BEHAVIOUR
//  Beat transfer: din_valid & din_ready. Clock and reset: one clock; reset is synchronous and active-high.
//  FSM states: IDLE, VIDEO, CONTROL, DISCARD. Reset -> IDLE.
//  Reset values: width=0, height=0, interlaced=0, vip_ctrl_valid=0, protocol_error=0, nibble counter=0.
//  din_ready = dout_ready in VIDEO (except an sop beat, which is always accepted); 1 in every other state.
//  IDLE: non-sop beats are dropped silently.
//    sop beat, type = din_data[3:0]:
//      0x0   -> VIDEO
//      0xF   -> CONTROL, clear nibble counter
//      other -> DISCARD
//    sop&eop together: type 0 -> stay IDLE, no output; type F -> truncated (see below); other -> IDLE.
//  VIDEO: pass-through with 0 latency. dout_valid = din_valid & ~din_sop; dout_data = din_data.
//    end_of_video = dout_valid & din_eop. eop transfer -> IDLE.
//  CONTROL: nibble index n = cnt + s for symbol s; if n < 9, stage din_data[s*BPS+3 : s*BPS].
//    Nibble order: w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], interlaced.
//    cnt <= min(cnt + SPB, 9), 4-bit counter, saturating. Symbols beyond nibble 8 are ignored.
//  Control eop transfer: if all 9 nibbles staged, width/height/interlaced load atomically on that clock edge.
//    vip_ctrl_valid is high the following cycle.
//    Otherwise the packet is truncated: outputs are unchanged and protocol_error pulses. Either way -> IDLE.
//  DISCARD: accept and drop beats until eop -> IDLE.
//  sop while in VIDEO/CONTROL/DISCARD: open packet abandoned. protocol_error pulses.
//    No end_of_video and no register update. The sop beat is parsed as a new header, same as IDLE.
//  Staging registers are separate from the outputs, so partial packets never show on width/height.
//  rst mid-packet: all state cleared; the remainder of the packet is dropped in IDLE until the next sop.
//  vip_ctrl_valid and protocol_error are registered, 1 cycle long, never stretched.
// TESTING
//  1. SPB=3 control packet: 0x00000F(sop), 0x080700, 0x040000, 0x030803(eop).
//     -> width=0x0780, height=0x0438, interlaced=3. vip_ctrl_valid for exactly 1 cycle after eop. dout_valid stays 0.
//  2. Video packet: header 0x000000, then D1..D3 with dout_ready toggling 1,0,1,0,1.
//     -> D1..D3 out in order with no header. din_ready==dout_ready. end_of_video only with D3.
//  3. Control packet with eop on beat 2 (6 nibbles) after test 1.
//     -> width/height/interlaced keep 0x0780/0x0438/3. protocol_error pulses once. No vip_ctrl_valid.
//  4. Video header, D1, then a new sop type F packet.
//     -> D1 forwarded, no end_of_video, protocol_error pulse. Control packet decodes normally afterwards.
//  5. Type 0x5 packet of 5 beats with dout_ready=0.
//     -> din_ready=1 on every beat, dout_valid never 1, outputs unchanged.
//  6. rst asserted after beat 2 of a control packet, then a full packet from test 1.
//     -> all outputs 0 during and after reset; the new packet yields 0x0780/0x0438/3.

Source files
------------

// File: rtl/alt_vipcts131_common_control_packet_decoder.sv
// Input-side VIP Avalon-ST parser: decodes control packets into width/height/interlaced,
// forwards video payload without its header beat, and drops every other packet type.
module alt_vipcts131_common_control_packet_decoder #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        end_of_video,
    output logic [15:0]                                 width,
    output logic [15:0]                                 height,
    output logic [3:0]                                  interlaced,
    output logic                                        vip_ctrl_valid,
    output logic                                        protocol_error
);

    typedef enum logic [1:0] {IDLE, VIDEO, CONTROL, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  nib_q [0:8];
    logic [3:0]  nib_d [0:8];
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [3:0]  interlaced_q, interlaced_d;
    logic        ctrlValid_q, ctrlValid_d;
    logic        protErr_q, protErr_d;
    logic        xfer;
    logic [3:0]  pktType;
    logic [4:0]  cntSum;

    // An sop beat is always taken so a stalled video consumer cannot block header parsing.
    assign din_ready    = (state_q == VIDEO) ? (dout_ready | din_sop) : 1'b1;
    assign dout_valid   = (state_q == VIDEO) & din_valid & ~din_sop;
    assign dout_data    = din_data;
    assign end_of_video = dout_valid & din_eop;

    assign width          = width_q;
    assign height         = height_q;
    assign interlaced     = interlaced_q;
    assign vip_ctrl_valid = ctrlValid_q;
    assign protocol_error = protErr_q;

    assign xfer    = din_valid & din_ready;
    assign pktType = din_data[3:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nib_d        = nib_q;
        width_d      = width_q;
        height_d     = height_q;
        interlaced_d = interlaced_q;
        ctrlValid_d  = 1'b0;
        protErr_d    = 1'b0;
        cntSum       = {1'b0, cnt_q} + 5'(SYMBOLS_PER_BEAT);

        if (xfer) begin
            if (din_sop) begin
                if (state_q != IDLE) begin
                    protErr_d = 1'b1;
                end
                if (pktType == 4'h0) begin
                    state_d = din_eop ? IDLE : VIDEO;
                end else if (pktType == 4'hF) begin
                    cnt_d = 4'd0;
                    if (din_eop) begin
                        protErr_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = CONTROL;
                    end
                end else begin
                    state_d = din_eop ? IDLE : DISCARD;
                end
            end else begin
                case (state_q)
                    VIDEO, DISCARD: begin
                        if (din_eop) begin
                            state_d = IDLE;
                        end
                    end
                    CONTROL: begin
                        // Symbol s of this beat carries nibble cnt+s; anything past nibble 8 is ignored.
                        for (int n = 0; n < 9; n++) begin
                            for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
                                if (({1'b0, cnt_q} + 5'(s)) == 5'(n)) begin
                                    nib_d[n] = din_data[s*BITS_PER_SYMBOL +: 4];
                                end
                            end
                        end
                        cnt_d = (cntSum > 5'd9) ? 4'd9 : cntSum[3:0];
                        if (din_eop) begin
                            state_d = IDLE;
                            if (cnt_d == 4'd9) begin
                                width_d      = {nib_d[0], nib_d[1], nib_d[2], nib_d[3]};
                                height_d     = {nib_d[4], nib_d[5], nib_d[6], nib_d[7]};
                                interlaced_d = nib_d[8];
                                ctrlValid_d  = 1'b1;
                            end else begin
                                protErr_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            nib_q        <= '{default: 4'd0};
            width_q      <= 16'd0;
            height_q     <= 16'd0;
            interlaced_q <= 4'd0;
            ctrlValid_q  <= 1'b0;
            protErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nib_q        <= nib_d;
            width_q      <= width_d;
            height_q     <= height_d;
            interlaced_q <= interlaced_d;
            ctrlValid_q  <= ctrlValid_d;
            protErr_q    <= protErr_d;
        end
    end

endmodule

// File: tb/tb_alt_vipcts131_common_control_packet_decoder.sv
// Scoreboard bench for the control packet decoder: stimulus pushes expected video beats,
// control updates and error pulses; monitors pop and compare as the DUT presents them.
module tb_alt_vipcts131_common_control_packet_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_ready;
    logic        din_valid;
    logic        din_sop;
    logic        din_eop;
    logic [23:0] din_data;
    logic        dout_ready;
    logic        dout_valid;
    logic [23:0] dout_data;
    logic        end_of_video;
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlaced;
    logic        vip_ctrl_valid;
    logic        protocol_error;

    int assertCount = 0;
    int failCount   = 0;
    int errPending  = 0;

    typedef struct packed {
        logic [23:0] data;
        logic        eov;
    } vidExp_t;

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  i;
    } ctrlExp_t;

    vidExp_t  vidQ[$];
    ctrlExp_t ctrlQ[$];

    alt_vipcts131_common_control_packet_decoder #(
        .BITS_PER_SYMBOL (8),
        .SYMBOLS_PER_BEAT(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din_ready     (din_ready),
        .din_valid     (din_valid),
        .din_sop       (din_sop),
        .din_eop       (din_eop),
        .din_data      (din_data),
        .dout_ready    (dout_ready),
        .dout_valid    (dout_valid),
        .dout_data     (dout_data),
        .end_of_video  (end_of_video),
        .width         (width),
        .height        (height),
        .interlaced    (interlaced),
        .vip_ctrl_valid(vip_ctrl_valid),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic sop, input logic eop, input logic [23:0] data,
                                 output int waited);
        logic acc;
        logic done;
        done      = 1'b0;
        waited    = 0;
        din_valid = 1'b1;
        din_sop   = sop;
        din_eop   = eop;
        din_data  = data;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
            waited++;
        end
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        if (!done) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL handshake_timeout: got no din_ready expected din_ready within 30 cycles");
        end
    endtask

    task automatic sendBeat(input logic sop, input logic eop, input logic [23:0] data);
        int w;
        applyStimulus(sop, eop, data, w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] i);
        checkOutput({tag, "_width"}, 40'(width), 40'(w));
        checkOutput({tag, "_height"}, 40'(height), 40'(h));
        checkOutput({tag, "_interlaced"}, 40'(interlaced), 40'(i));
    endtask

    // Video monitor: any transferred beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (dout_valid && vidQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_dout_valid: got 1 expected 0 (data %h)", dout_data);
        end else if (dout_valid && dout_ready) begin
            vidExp_t e;
            e = vidQ.pop_front();
            checkOutput("video_data", 40'(dout_data), 40'(e.data));
            checkOutput("video_eov", 40'(end_of_video), 40'(e.eov));
        end
    end

    // Control and error monitors: each pulse consumes one expected event.
    always @(negedge clk) begin
        if (vip_ctrl_valid) begin
            if (ctrlQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_vip_ctrl_valid: got 1 expected 0");
            end else begin
                ctrlExp_t e;
                e = ctrlQ.pop_front();
                checkOutput("ctrl_width", 40'(width), 40'(e.w));
                checkOutput("ctrl_height", 40'(height), 40'(e.h));
                checkOutput("ctrl_interlaced", 40'(interlaced), 40'(e.i));
            end
        end
        if (protocol_error) begin
            assertCount++;
            if (errPending == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_protocol_error: got 1 expected 0");
            end else begin
                errPending--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   waited;
        int   bi;
        logic [23:0] vbeats [4];

        rst        = 1'b1;
        din_valid  = 1'b0;
        din_sop    = 1'b0;
        din_eop    = 1'b0;
        din_data   = '0;
        dout_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkRegs("reset", 16'h0, 16'h0, 4'h0);
        checkOutput("reset_vip_ctrl_valid", 40'(vip_ctrl_valid), 40'd0);
        checkOutput("reset_protocol_error", 40'(protocol_error), 40'd0);
        checkOutput("reset_din_ready", 40'(din_ready), 40'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        $display("[TB] test 1: full control packet");
        ctrlQ.push_back('{w: 16'h0780, h: 16'h0438, i: 4'h3});
        sendBeat(1'b1, 1'b0, 24'h00000F);
        sendBeat(1'b0, 1'b0, 24'h080700);
        sendBeat(1'b0, 1'b0, 24'h040000);
        sendBeat(1'b0, 1'b1, 24'h030803);
        idle(3);
        checkRegs("t1", 16'h0780, 16'h0438, 4'h3);

        $display("[TB] test 2: video packet with toggling dout_ready");
        vbeats[0] = 24'h000000;
        vbeats[1] = 24'h112233;
        vbeats[2] = 24'h445566;
        vbeats[3] = 24'h778899;
        vidQ.push_back('{data: 24'h112233, eov: 1'b0});
        vidQ.push_back('{data: 24'h445566, eov: 1'b0});
        vidQ.push_back('{data: 24'h778899, eov: 1'b1});
        bi = 0;
        for (int c = 0; c < 20 && bi < 4; c++) begin
            logic acc;
            din_valid  = 1'b1;
            din_sop    = (bi == 0);
            din_eop    = (bi == 3);
            din_data   = vbeats[bi];
            dout_ready = (c % 2 == 0);
            @(negedge clk);
            checkOutput("t2_din_ready", 40'(din_ready), (bi == 0) ? 40'd1 : 40'(dout_ready));
            acc = din_ready;
            @(posedge clk);
            #1;
            if (acc) bi++;
        end
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        dout_ready = 1'b0;
        checkOutput("t2_beats_sent", 40'(bi), 40'd4);
        idle(2);
        checkOutput("t2_video_drained", 40'(vidQ.size()), 40'd0);

        $display("[TB] test 3: truncated control packet");
        sendBeat(1'b1, 1'b0, 24'h00000F);
        sendBeat(1'b0, 1'b0, 24'h080700);
        errPending++;
        sendBeat(1'b0, 1'b1, 24'h040000);
        idle(3);
        checkRegs("t3", 16'h0780, 16'h0438, 4'h3);
        checkOutput("t3_err_seen", 40'(errPending), 40'd0);

        $display("[TB] test 4: sop inside open video packet");
        dout_ready = 1'b1;
        sendBeat(1'b1, 1'b0, 24'h000000);
        vidQ.push_back('{data: 24'hAABBCC, eov: 1'b0});
        sendBeat(1'b0, 1'b0, 24'hAABBCC);
        errPending++;
        sendBeat(1'b1, 1'b0, 24'h00000F);
        sendBeat(1'b0, 1'b0, 24'h040100);
        sendBeat(1'b0, 1'b0, 24'h000000);
        ctrlQ.push_back('{w: 16'h0140, h: 16'h00F0, i: 4'hA});
        sendBeat(1'b0, 1'b1, 24'h0A000F);
        idle(3);
        dout_ready = 1'b0;
        checkRegs("t4", 16'h0140, 16'h00F0, 4'hA);
        checkOutput("t4_err_seen", 40'(errPending), 40'd0);
        checkOutput("t4_video_drained", 40'(vidQ.size()), 40'd0);

        $display("[TB] test 5: discarded packet type 5");
        applyStimulus(1'b1, 1'b0, 24'h123405, waited);
        checkOutput("t5_sop_ready", 40'(waited), 40'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, (k == 3), 24'h0F0F0F + 24'(k), waited);
            checkOutput("t5_beat_ready", 40'(waited), 40'd0);
        end
        idle(2);
        checkRegs("t5", 16'h0140, 16'h00F0, 4'hA);

        $display("[TB] test 6: reset mid control packet");
        sendBeat(1'b1, 1'b0, 24'h00000F);
        sendBeat(1'b0, 1'b0, 24'h080700);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkRegs("t6_in_reset", 16'h0, 16'h0, 4'h0);
        checkOutput("t6_reset_vip_ctrl_valid", 40'(vip_ctrl_valid), 40'd0);
        checkOutput("t6_reset_protocol_error", 40'(protocol_error), 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendBeat(1'b0, 1'b0, 24'h040000);
        sendBeat(1'b0, 1'b1, 24'h030803);
        idle(3);
        checkRegs("t6_after_reset", 16'h0, 16'h0, 4'h0);
        ctrlQ.push_back('{w: 16'h0780, h: 16'h0438, i: 4'h3});
        sendBeat(1'b1, 1'b0, 24'h00000F);
        sendBeat(1'b0, 1'b0, 24'h080700);
        sendBeat(1'b0, 1'b0, 24'h040000);
        sendBeat(1'b0, 1'b1, 24'h030803);
        idle(3);
        checkRegs("t6_final", 16'h0780, 16'h0438, 4'h3);

        idle(2);
        checkOutput("end_ctrl_queue_empty", 40'(ctrlQ.size()), 40'd0);
        checkOutput("end_video_queue_empty", 40'(vidQ.size()), 40'd0);
        checkOutput("end_err_pending", 40'(errPending), 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
